mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Y86-64 memory stage, directly downstream of execute: consumes icode/valE/valA/valP.
//  Issues at most one data-memory read or write per instruction over a req/ack bus.
//  Returns valM and a Y86 status code to write-back through a valid/ready handshake.
// PARAMETERS
//  MEM_BYTES    65536  data memory size in bytes; an address with addr+8 > MEM_BYTES gives ADR
//  TIMEOUT_CYC  255    max cycles dmem_req_o waits for dmem_ack_i before ADR (8-bit counter)
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   synchronous reset, active-high
//  in_valid_i     in   1   execute presents an instruction
//  in_ready_o     out  1   stage can accept (high only in IDLE)
//  icode_i        in   4   instruction code
//  valE_i         in   64  execute result / effective address
//  valA_i         in   64  register A value (store data, pop/ret address)
//  valP_i         in   64  fall-through PC (call store data)
//  out_valid_o    out  1   result valid toward write-back
//  out_ready_i    in   1   write-back accepts result
//  valE_o         out  64  registered copy of valE_i
//  valM_o         out  64  loaded data; 0 for non-loads
//  stat_o         out  3   1=AOK 2=HLT 3=ADR 4=INS
//  dmem_req_o     out  1   memory request, held until ack
//  dmem_we_o      out  1   1=write, 0=read; stable while req
//  dmem_addr_o    out  64  byte address; stable while req
//  dmem_wdata_o   out  64  write data; stable while req
//  dmem_ack_i     in   1   request completes this cycle
//  dmem_rdata_i   in   64  read data, valid with ack on reads
// BEHAVIOUR
//  Reset: FSM=IDLE; in_ready_o=1; out_valid_o=0; dmem_req_o=0.
//  Reset: dmem_we_o=0; valE_o=valM_o=dmem_addr_o=dmem_wdata_o=0; stat_o=AOK; counter=0.
//  Reset mid-access drops dmem_req_o next cycle and returns to IDLE; no retry.
//  FSM states: IDLE, ACCESS, DONE.
//  IDLE: on in_valid_i, capture all inputs.
//  IDLE -> ACCESS when the instruction needs memory and the address is legal.
//  IDLE -> DONE otherwise, with the result visible 1 cycle after accept.
//  Access table:
//   MRMOVL: read at valE.
//   POPL, RET: read at valA.
//   RMMOVL, PUSHL: write valA at valE.
//   CALL: write valP at valE.
//   All other icodes: no access.
//  Status: HALT -> HLT; icode > 4'hB -> INS; illegal address -> ADR with no request issued.
//  ACCESS: dmem_req_o=1 with address, data and we held constant.
//  ACCESS, on dmem_ack_i: latch rdata into valM_o for reads; -> DONE with AOK.
//  ACCESS, on timeout: counter counts req cycles without ack.
//   When count reaches TIMEOUT_CYC: drop req, -> DONE, stat=ADR, valM_o=0.
//   An ack arriving in the same cycle as the timeout wins (AOK).
//  Memory latency: minimum 2 cycles accept-to-result (ack in the first ACCESS cycle).
//  DONE: out_valid_o=1, outputs stable; on out_ready_i -> IDLE.
//  in_ready_o=0 outside IDLE; no new accept in the DONE->IDLE handoff cycle.
//  Address check: 64-bit compare of addr > MEM_BYTES-8, no wrap.
//   addr >= 2^64-7 is also ADR.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: memory op with addr[2:0]!=0 gives ADR, no request issued.
//  MEM_ALIGN_CHECK_EN undefined: unaligned addresses are issued unchanged; only range/timeout give ADR.
// STRUCTURE
//  Shared package y86_pkg:
//   icode localparams NOP..POPL.
//   STAT_AOK/HLT/ADR/INS.
//   Memory-stage FSM state encoding.
//  Sub-module mem_addr_sel (combinational):
//   Inputs: icode, valE, valA, valP.
//   Outputs: need_mem, we, addr, wdata, addr_err.
//  FSM, counter and output registers live in mem_stage.
// TESTING
//  1. MRMOVL valE=0x100, ack after 3 cycles with rdata=0xDEAD
//     -> req held 3 cycles at addr 0x100, we=0; valM=0xDEAD, stat=1.
//  2. CALL valE=0x1F8 valP=0x42
//     -> write req addr 0x1F8 wdata 0x42; valM=0, stat=1.
//  3. RMMOVL valE=MEM_BYTES-4
//     -> no dmem_req_o, out_valid_o 1 cycle after accept, stat=3.
//  4. POPL valA=0x80, never ack
//     -> req high exactly 255 cycles, then stat=3, valM=0.
//  5. OPL (icode 6) valE=7 with out_ready_i low 5 cycles
//     -> out_valid_o held, valE_o=7, in_ready_o=0 until handshake.
//  6. MRMOVL valE=0x103: EN -> stat=3, no req; undefined -> read at 0x103.
//  7. rst_i pulse during ACCESS -> next cycle req=0, IDLE.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the
// memory-stage FSM state encoding.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        MS_IDLE   = 2'd0,
        MS_ACCESS = 2'd1,
        MS_DONE   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master)
// and the data memory (slave).
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        ack;
    logic [63:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_addr_sel.sv
// Decodes which data-memory access an instruction needs and whether its address is legal.
// Define MEM_ALIGN_CHECK_EN to also reject addresses that are not 8-byte aligned.
module mem_addr_sel
    import y86_pkg::*;
#(
    parameter logic [63:0] MEM_BYTES = 64'd65536
) (
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        need_mem,
    output logic        we,
    output logic [63:0] addr,
    output logic [63:0] wdata,
    output logic        addr_err
);

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        need_mem = 1'b0;
        we       = 1'b0;
        addr     = valE;
        wdata    = valA;
        unique case (icode)
            I_MRMOVL: need_mem = 1'b1;
            I_POPL, I_RET: begin
                need_mem = 1'b1;
                addr     = valA;
            end
            I_RMMOVL, I_PUSHL: begin
                need_mem = 1'b1;
                we       = 1'b1;
            end
            I_CALL: begin
                need_mem = 1'b1;
                we       = 1'b1;
                wdata    = valP;
            end
            default: ;
        endcase
    end

    // Comparing against MEM_BYTES-8 avoids the wrap that addr+8 would suffer near 2^64.
`ifdef MEM_ALIGN_CHECK_EN
    assign addr_err = need_mem && ((addr > (MEM_BYTES - 64'd8)) || (addr[2:0] != 3'b000));
`else
    assign addr_err = need_mem && (addr > (MEM_BYTES - 64'd8));
`endif

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: one data-memory access per instruction with ack timeout,
// result handed to write-back over valid/ready. MEM_ALIGN_CHECK_EN is honoured in mem_addr_sel.
module mem_stage
    import y86_pkg::*;
#(
    parameter logic [63:0] MEM_BYTES   = 64'd65536,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [3:0]  icode_i,
    input  logic [63:0] valE_i,
    input  logic [63:0] valA_i,
    input  logic [63:0] valP_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] valE_o,
    output logic [63:0] valM_o,
    output logic [2:0]  stat_o,
    mem_stage_if.master dmem
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    mem_state_e  state;
    logic [7:0]  wait_cnt;

    logic        sel_need_mem;
    logic        sel_we;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic        sel_addr_err;

    mem_addr_sel #(
        .MEM_BYTES (MEM_BYTES)
    ) u_addr_sel (
        .icode    (icode_i),
        .valE     (valE_i),
        .valA     (valA_i),
        .valP     (valP_i),
        .need_mem (sel_need_mem),
        .we       (sel_we),
        .addr     (sel_addr),
        .wdata    (sel_wdata),
        .addr_err (sel_addr_err)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= MS_IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            dmem.req    <= 1'b0;
            dmem.we     <= 1'b0;
            dmem.addr   <= '0;
            dmem.wdata  <= '0;
            valE_o      <= '0;
            valM_o      <= '0;
            stat_o      <= STAT_AOK;
            wait_cnt    <= '0;
        end else begin
            unique case (state)
                MS_IDLE: begin
                    if (in_valid_i) begin
                        valE_o     <= valE_i;
                        valM_o     <= '0;
                        wait_cnt   <= '0;
                        in_ready_o <= 1'b0;
                        if (sel_need_mem && !sel_addr_err) begin
                            state      <= MS_ACCESS;
                            stat_o     <= STAT_AOK;
                            dmem.req   <= 1'b1;
                            dmem.we    <= sel_we;
                            dmem.addr  <= sel_addr;
                            dmem.wdata <= sel_wdata;
                        end else begin
                            state       <= MS_DONE;
                            out_valid_o <= 1'b1;
                            if (icode_i == I_HALT)      stat_o <= STAT_HLT;
                            else if (icode_i > I_POPL)  stat_o <= STAT_INS;
                            else if (sel_addr_err)      stat_o <= STAT_ADR;
                            else                        stat_o <= STAT_AOK;
                        end
                    end
                end
                MS_ACCESS: begin
                    // An ack in the timeout cycle takes priority over the timeout.
                    if (dmem.ack) begin
                        if (!dmem.we) valM_o <= dmem.rdata;
                        stat_o      <= STAT_AOK;
                        dmem.req    <= 1'b0;
                        dmem.we     <= 1'b0;
                        out_valid_o <= 1'b1;
                        state       <= MS_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        valM_o      <= '0;
                        stat_o      <= STAT_ADR;
                        dmem.req    <= 1'b0;
                        dmem.we     <= 1'b0;
                        out_valid_o <= 1'b1;
                        state       <= MS_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                MS_DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= MS_IDLE;
                    end
                end
                default: begin
                    state       <= MS_IDLE;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                    dmem.req    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed corner cases plus randomized
// instructions checked against a rule-level reference model.
`timescale 1ns/1ps
module tb_mem_stage;
    import y86_pkg::*;

    localparam logic [63:0] MEM_BYTES   = 64'd65536;
    localparam int          TIMEOUT_CYC = 255;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  icode_i;
    logic [63:0] valE_i;
    logic [63:0] valA_i;
    logic [63:0] valP_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] valE_o;
    logic [63:0] valM_o;
    logic [2:0]  stat_o;

    mem_stage_if dmem ();

    mem_stage #(
        .MEM_BYTES   (MEM_BYTES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .icode_i     (icode_i),
        .valE_i      (valE_i),
        .valA_i      (valA_i),
        .valP_i      (valP_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .valE_o      (valE_o),
        .valM_o      (valM_o),
        .stat_o      (stat_o),
        .dmem        (dmem)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          mem;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  stat;
        logic [63:0] valm;
        int          reqs;
        int          lat;
    } exp_t;

    // ack_after = n: memory acks during the n-th request cycle; 0 means never.
    function automatic exp_t model(logic [3:0] ic, logic [63:0] ve, logic [63:0] va,
                                   logic [63:0] vp, int ack_after, logic [63:0] rd);
        exp_t e;
        bit   illegal;
        e.mem = 0; e.we = 0; e.addr = '0; e.wdata = '0;
        e.stat = STAT_AOK; e.valm = '0; e.reqs = 0; e.lat = 1;
        if (ic == I_HALT) e.stat = STAT_HLT;
        else if (ic > I_POPL) e.stat = STAT_INS;
        else begin
            case (ic)
                I_MRMOVL:          begin e.mem = 1; e.addr = ve; end
                I_POPL, I_RET:     begin e.mem = 1; e.addr = va; end
                I_RMMOVL, I_PUSHL: begin e.mem = 1; e.we = 1; e.addr = ve; e.wdata = va; end
                I_CALL:            begin e.mem = 1; e.we = 1; e.addr = ve; e.wdata = vp; end
                default: ;
            endcase
            if (e.mem) begin
                illegal = ({1'b0, e.addr} + 65'd8) > {1'b0, MEM_BYTES};
`ifdef MEM_ALIGN_CHECK_EN
                if (e.addr % 8 != 0) illegal = 1;
`endif
                if (illegal) begin
                    e.mem  = 0;
                    e.stat = STAT_ADR;
                end else if (ack_after >= 1 && ack_after <= TIMEOUT_CYC) begin
                    e.reqs = ack_after;
                    e.lat  = ack_after + 1;
                    e.valm = e.we ? 64'd0 : rd;
                end else begin
                    e.reqs = TIMEOUT_CYC;
                    e.lat  = TIMEOUT_CYC + 1;
                    e.stat = STAT_ADR;
                end
            end
        end
        return e;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic accept(input string tag, input logic [3:0] ic, input logic [63:0] ve,
                          input logic [63:0] va, input logic [63:0] vp);
        int w = 0;
        while (!in_ready_o && w < 20) begin
            @(negedge clk_i);
            w++;
        end
        check({tag, "_in_ready"}, 64'(in_ready_o), 64'd1);
        in_valid_i = 1'b1; icode_i = ic; valE_i = ve; valA_i = va; valP_i = vp;
        @(negedge clk_i);
        in_valid_i = 1'b0; icode_i = 4'($urandom); valE_i = rand64(); valA_i = rand64(); valP_i = rand64();
    endtask

    task automatic run_instr(input string tag, input logic [3:0] ic, input logic [63:0] ve,
                             input logic [63:0] va, input logic [63:0] vp, input int ack_after,
                             input logic [63:0] rd, input int rdy_dly);
        exp_t        e;
        int          cyc, reqs;
        bit          seen, stable, held;
        logic [63:0] a0, wd0;
        logic        we0;
        logic [2:0]  st0;
        e = model(ic, ve, va, vp, ack_after, rd);
        accept(tag, ic, ve, va, vp);
        cyc = 1; reqs = 0; seen = 0; stable = 1;
        a0 = '0; wd0 = '0; we0 = 1'b0;
        while (!out_valid_o && cyc <= TIMEOUT_CYC + 20) begin
            if (dmem.req) begin
                reqs++;
                if (!seen) begin
                    a0 = dmem.addr; wd0 = dmem.wdata; we0 = dmem.we; seen = 1;
                end else if (dmem.addr !== a0 || dmem.wdata !== wd0 || dmem.we !== we0) begin
                    stable = 0;
                end
                if (in_ready_o) stable = 0;
                dmem.ack   = (reqs == ack_after);
                dmem.rdata = (reqs == ack_after) ? rd : rand64();
            end else begin
                dmem.ack   = 1'b0;
                dmem.rdata = rand64();
            end
            @(negedge clk_i);
            cyc++;
        end
        dmem.ack = 1'b0;
        check({tag, "_out_valid"}, 64'(out_valid_o), 64'd1);
        check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
        check({tag, "_req_cycles"}, 64'(reqs), 64'(e.reqs));
        check({tag, "_req_stable"}, 64'(stable), 64'd1);
        check({tag, "_req_dropped"}, 64'(dmem.req), 64'd0);
        if (e.mem) begin
            check({tag, "_addr"}, a0, e.addr);
            check({tag, "_we"}, 64'(we0), 64'(e.we));
            if (e.we) check({tag, "_wdata"}, wd0, e.wdata);
        end
        check({tag, "_valE"}, valE_o, ve);
        check({tag, "_valM"}, valM_o, e.valm);
        check({tag, "_stat"}, 64'(stat_o), 64'(e.stat));
        st0 = stat_o; held = 1;
        repeat (rdy_dly) begin
            @(negedge clk_i);
            if (!out_valid_o || in_ready_o || stat_o !== st0 || valE_o !== ve || valM_o !== e.valm)
                held = 0;
        end
        check({tag, "_held"}, 64'(held), 64'd1);
        out_ready_i = 1'b1;
        check({tag, "_handoff_in_ready"}, 64'(in_ready_o), 64'd0);
        @(negedge clk_i);
        out_ready_i = 1'b0;
        check({tag, "_valid_drop"}, 64'(out_valid_o), 64'd0);
        check({tag, "_idle_ready"}, 64'(in_ready_o), 64'd1);
    endtask

    initial begin
        logic [3:0]  ic;
        logic [63:0] ad;
        int          sel, ack_after, rdy;
        int          n;

        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        icode_i = '0; valE_i = '0; valA_i = '0; valP_i = '0;
        dmem.ack = 1'b0; dmem.rdata = '0;
        repeat (3) @(negedge clk_i);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_req", 64'(dmem.req), 64'd0);
        check("rst_we", 64'(dmem.we), 64'd0);
        check("rst_addr", dmem.addr, 64'd0);
        check("rst_wdata", dmem.wdata, 64'd0);
        check("rst_valE", valE_o, 64'd0);
        check("rst_valM", valM_o, 64'd0);
        check("rst_stat", 64'(stat_o), 64'(STAT_AOK));
        rst_i = 1'b0;
        @(negedge clk_i);

        run_instr("t1_mrmovl", I_MRMOVL, 64'h100, rand64(), rand64(), 3, 64'hDEAD, 0);
        run_instr("t2_call", I_CALL, 64'h1F8, rand64(), 64'h42, 2, rand64(), 1);
        run_instr("t3_rmmovl_oob", I_RMMOVL, MEM_BYTES - 64'd4, rand64(), rand64(), 1, rand64(), 0);
        run_instr("t4_popl_timeout", I_POPL, rand64(), 64'h80, rand64(), 0, rand64(), 0);
        run_instr("t5_opl_stall", I_OPL, 64'd7, rand64(), rand64(), 1, rand64(), 5);
        run_instr("t6_unaligned", I_MRMOVL, 64'h103, rand64(), rand64(), 1, 64'h1234_5678_9ABC_DEF0, 0);
        run_instr("b_last_legal", I_MRMOVL, MEM_BYTES - 64'd8, rand64(), rand64(), 1, 64'hCAFE, 0);
        run_instr("b_first_illegal", I_PUSHL, MEM_BYTES - 64'd7, rand64(), rand64(), 1, rand64(), 0);
        run_instr("b_wrap", I_RET, rand64(), 64'hFFFF_FFFF_FFFF_FFFC, rand64(), 1, rand64(), 0);
        run_instr("b_ack_at_timeout", I_POPL, rand64(), 64'h8, rand64(), TIMEOUT_CYC, 64'h77, 0);
        run_instr("b_halt", I_HALT, 64'h10, rand64(), rand64(), 1, rand64(), 2);
        run_instr("b_ins", 4'hC, 64'h10, rand64(), rand64(), 1, rand64(), 0);

        // Reset in the middle of an outstanding access.
        accept("t7_rst", I_MRMOVL, 64'h200, rand64(), rand64());
        repeat (3) @(negedge clk_i);
        check("t7_req_before", 64'(dmem.req), 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("t7_req_dropped", 64'(dmem.req), 64'd0);
        check("t7_in_ready", 64'(in_ready_o), 64'd1);
        check("t7_out_valid", 64'(out_valid_o), 64'd0);
        @(negedge clk_i);
        check("t7_no_retry", 64'(dmem.req), 64'd0);

        for (int i = 0; i < 50; i++) begin
            n   = $urandom_range(0, 3);
            ic  = (n == 0) ? 4'($urandom) : 4'($urandom_range(4, 11));
            sel = $urandom_range(0, 3);
            case (sel)
                0:       ad = {48'd0, 13'($urandom), 3'b000};
                1:       ad = MEM_BYTES - 64'd16 + 64'($urandom_range(0, 15));
                2:       ad = rand64();
                default: ad = 64'($urandom_range(0, 4095));
            endcase
            ack_after = ($urandom_range(0, 14) == 0) ? 0 : $urandom_range(1, 5);
            rdy       = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1)
                run_instr($sformatf("rnd%0d", i), ic, ad, rand64(), rand64(), ack_after, rand64(), rdy);
            else
                run_instr($sformatf("rnd%0d", i), ic, rand64(), ad, rand64(), ack_after, rand64(), rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
